bus_reg_assembler: RTL and testbench

Sits directly downstream of the bus synchronizer stage and consumes its registered strobe/register/byte outputs. Assembles even/odd byte writes into 16-bit register updates for a small bank of memory-access registers, and returns register bytes on reads. Turns writes and reads of the DATA register into single-word memory requests with address auto-increment, using a req/ack handshake to the VRAM arbiter.

---
 rtl/xv_pkg.sv | 21 ++
 rtl/bus_reg_assembler.sv | 149 ++++++++++++++
 tb/tb_bus_reg_assembler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xv_pkg.sv
// Shared definitions for the bus register assembler: register map,
// STATUS bit positions and arbiter state encoding.
package xv;

    localparam logic [3:0] XM_RD_INCR = 4'd0;
    localparam logic [3:0] XM_RD_ADDR = 4'd1;
    localparam logic [3:0] XM_WR_INCR = 4'd2;
    localparam logic [3:0] XM_WR_ADDR = 4'd3;
    localparam logic [3:0] XM_DATA    = 4'd4;
    localparam logic [3:0] XM_STATUS  = 4'd5;

    localparam int unsigned XM_STATUS_BUSY = 15;
    localparam int unsigned XM_STATUS_OVF  = 14;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WR_REQ,
        ARB_RD_REQ
    } arb_state_t;

endpackage

// File: rtl/bus_reg_assembler.sv
// Assembles byte writes into 16-bit memory-access registers and runs req/ack memory cycles.
// Optional: define BUS_REG_RD_PREFETCH_EN to prefetch the next word on an odd-byte DATA read.
module bus_reg_assembler
    import xv::*;
(
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        write_strobe_i,
    input  logic        read_strobe_i,
    input  logic [3:0]  reg_num_i,
    input  logic        bytesel_i,
    input  logic [7:0]  bytedata_i,
    output logic [7:0]  rd_byte_o,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_data_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_data_i
);

    logic [7:0]  msb_latch;
    logic [15:0] rd_incr, rd_addr, wr_incr, wr_addr, wr_buf, rd_buf;
    logic        wr_pend, rd_pend, ovf;
    arb_state_t  state, state_nxt;

    logic [15:0] word, reg_word;
    logic [15:0] rd_addr_d, wr_addr_d, wr_buf_d;
    logic        wr_commit, wr_ack, rd_ack;
    logic        data_wr, data_accept, rd_addr_ld, rd_trig;
    logic        wr_pend_d, rd_pend_d, ovf_d;

    assign word       = {msb_latch, bytedata_i};
    assign wr_commit  = write_strobe_i & bytesel_i;
    assign wr_ack     = mem_ack_i && (state == ARB_WR_REQ);
    assign rd_ack     = mem_ack_i && (state == ARB_RD_REQ);
    assign data_wr    = wr_commit && (reg_num_i == XM_DATA);
    // An ack in the same cycle frees the write slot for the incoming word.
    assign data_accept = data_wr && (!wr_pend || wr_ack);
    assign rd_addr_ld = wr_commit && (reg_num_i == XM_RD_ADDR);

`ifdef BUS_REG_RD_PREFETCH_EN
    assign rd_trig = rd_addr_ld | (read_strobe_i & bytesel_i & (reg_num_i == XM_DATA));
`else
    assign rd_trig = rd_addr_ld;
`endif

    assign mem_req_o = (state != ARB_IDLE);

    // Next register/flag values; a CPU load of an address register overrides the increment.
    always_comb begin
        wr_addr_d = wr_addr;
        rd_addr_d = rd_addr;
        wr_buf_d  = wr_buf;
        wr_pend_d = wr_pend;
        rd_pend_d = rd_pend;
        ovf_d     = ovf;
        if (wr_ack) begin
            wr_addr_d = wr_addr + wr_incr;
            wr_pend_d = 1'b0;
        end
        if (rd_ack) begin
            rd_addr_d = rd_addr + rd_incr;
            rd_pend_d = 1'b0;
        end
        if (wr_commit && (reg_num_i == XM_WR_ADDR)) wr_addr_d = word;
        if (rd_addr_ld) rd_addr_d = word;
        if (rd_trig) rd_pend_d = 1'b1;
        if (data_accept) begin
            wr_buf_d  = word;
            wr_pend_d = 1'b1;
        end
        if (data_wr && !data_accept) ovf_d = 1'b1;
        if (wr_commit && (reg_num_i == XM_STATUS) && word[XM_STATUS_OVF]) ovf_d = 1'b0;
    end

    always_comb begin
        reg_word = '0;
        case (reg_num_i)
            XM_RD_INCR: reg_word = rd_incr;
            XM_RD_ADDR: reg_word = rd_addr;
            XM_WR_INCR: reg_word = wr_incr;
            XM_WR_ADDR: reg_word = wr_addr;
            XM_DATA:    reg_word = rd_buf;
            XM_STATUS: begin
                reg_word[XM_STATUS_BUSY] = wr_pend | rd_pend;
                reg_word[XM_STATUS_OVF]  = ovf;
            end
            default:    reg_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) state <= ARB_IDLE;
        else            state <= state_nxt;
    end

    // From idle, flags already include this cycle's commits so a request starts one cycle after the strobe.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE: begin
                if (wr_pend_d)      state_nxt = ARB_WR_REQ;
                else if (rd_pend_d) state_nxt = ARB_RD_REQ;
            end
            ARB_WR_REQ, ARB_RD_REQ: begin
                if (mem_ack_i) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            msb_latch  <= '0;
            rd_incr    <= '0;
            rd_addr    <= '0;
            wr_incr    <= '0;
            wr_addr    <= '0;
            wr_buf     <= '0;
            rd_buf     <= '0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            ovf        <= 1'b0;
            rd_byte_o  <= '0;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            if (write_strobe_i && !bytesel_i) msb_latch <= bytedata_i;
            if (wr_commit && (reg_num_i == XM_RD_INCR)) rd_incr <= word;
            if (wr_commit && (reg_num_i == XM_WR_INCR)) wr_incr <= word;
            rd_addr <= rd_addr_d;
            wr_addr <= wr_addr_d;
            wr_buf  <= wr_buf_d;
            wr_pend <= wr_pend_d;
            rd_pend <= rd_pend_d;
            ovf     <= ovf_d;
            if (rd_ack) rd_buf <= mem_data_i;
            if (read_strobe_i) rd_byte_o <= bytesel_i ? reg_word[7:0] : reg_word[15:8];
            if ((state == ARB_IDLE) && (state_nxt != ARB_IDLE)) begin
                mem_wr_o   <= (state_nxt == ARB_WR_REQ);
                mem_addr_o <= (state_nxt == ARB_WR_REQ) ? wr_addr_d : rd_addr_d;
                mem_data_o <= wr_buf_d;
            end
        end
    end

endmodule

// File: tb/tb_bus_reg_assembler.sv
// Self-checking bench for bus_reg_assembler against a transaction-level register model.
module tb_bus_reg_assembler;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        write_strobe_i = 1'b0;
    logic        read_strobe_i = 1'b0;
    logic [3:0]  reg_num_i = '0;
    logic        bytesel_i = 1'b0;
    logic [7:0]  bytedata_i = '0;
    logic [7:0]  rd_byte_o;
    logic        mem_req_o, mem_wr_o;
    logic [15:0] mem_addr_o, mem_data_o;
    logic        mem_ack_i = 1'b0;
    logic [15:0] mem_data_i = '0;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int unsigned m_rd_incr, m_rd_addr, m_wr_incr, m_wr_addr, m_wr_word, m_rd_buf;
    bit          m_wr_pend, m_rd_pend, m_ovf;

    always #5 clk = ~clk;

    bus_reg_assembler dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .write_strobe_i(write_strobe_i),
        .read_strobe_i (read_strobe_i),
        .reg_num_i     (reg_num_i),
        .bytesel_i     (bytesel_i),
        .bytedata_i    (bytedata_i),
        .rd_byte_o     (rd_byte_o),
        .mem_req_o     (mem_req_o),
        .mem_wr_o      (mem_wr_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rd_incr = 0; m_rd_addr = 0; m_wr_incr = 0; m_wr_addr = 0;
        m_wr_word = 0; m_rd_buf = 0;
        m_wr_pend = 0; m_rd_pend = 0; m_ovf = 0;
    endtask

    task automatic model_write(input int num, input logic [15:0] w);
        case (num)
            0: m_rd_incr = w;
            1: begin m_rd_addr = w; m_rd_pend = 1; end
            2: m_wr_incr = w;
            3: m_wr_addr = w;
            4: if (m_wr_pend) m_ovf = 1; else begin m_wr_pend = 1; m_wr_word = w; end
            5: if (w[14]) m_ovf = 0;
            default: ;
        endcase
    endtask

    function automatic logic [15:0] model_reg(input int num);
        case (num)
            0: return 16'(m_rd_incr);
            1: return 16'(m_rd_addr);
            2: return 16'(m_wr_incr);
            3: return 16'(m_wr_addr);
            4: return 16'(m_rd_buf);
            5: return {m_wr_pend | m_rd_pend, m_ovf, 14'h0};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic wr_byte(input int num, input logic sel, input logic [7:0] b);
        write_strobe_i = 1'b1;
        reg_num_i = num[3:0];
        bytesel_i = sel;
        bytedata_i = b;
        tick();
        write_strobe_i = 1'b0;
    endtask

    task automatic wr_reg(input int num, input logic [15:0] w);
        wr_byte(num, 1'b0, w[15:8]);
        wr_byte(num, 1'b1, w[7:0]);
        model_write(num, w);
    endtask

    // Waits for a request, checks its attributes and stability, then acks after dly cycles.
    task automatic serve(input logic exp_wr, input logic [15:0] exp_addr, input logic [15:0] exp_data,
                         input int unsigned dly, input logic [15:0] rdata);
        int unsigned n;
        n = 0;
        while (mem_req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {15'h0, mem_req_o}, 16'h0001);
        if (mem_req_o !== 1'b1) return;
        chk("req_wr", {15'h0, mem_wr_o}, {15'h0, exp_wr});
        chk("req_addr", mem_addr_o, exp_addr);
        if (exp_wr) chk("req_data", mem_data_o, exp_data);
        repeat (dly) begin
            tick();
            chk("req_hold", {15'h0, mem_req_o}, 16'h0001);
            chk("addr_hold", mem_addr_o, exp_addr);
        end
        mem_ack_i = 1'b1;
        mem_data_i = rdata;
        tick();
        mem_ack_i = 1'b0;
        mem_data_i = 16'($urandom());
        chk("req_drop", {15'h0, mem_req_o}, 16'h0000);
    endtask

    task automatic serve_write(input int unsigned dly);
        serve(1'b1, 16'(m_wr_addr), 16'(m_wr_word), dly, 16'($urandom()));
        m_wr_addr = (m_wr_addr + m_wr_incr) % 65536;
        m_wr_pend = 0;
    endtask

    task automatic serve_read(input int unsigned dly, input logic [15:0] rdata);
        serve(1'b0, 16'(m_rd_addr), 16'h0000, dly, rdata);
        m_rd_buf = rdata;
        m_rd_addr = (m_rd_addr + m_rd_incr) % 65536;
        m_rd_pend = 0;
    endtask

    task automatic rd_check(input int num, input string tag);
        logic [15:0] exp;
        logic [7:0]  hi, lo;
        exp = model_reg(num);
        read_strobe_i = 1'b1;
        reg_num_i = num[3:0];
        bytesel_i = 1'b0;
        tick();
        hi = rd_byte_o;
        bytesel_i = 1'b1;
        tick();
        lo = rd_byte_o;
        read_strobe_i = 1'b0;
        chk(tag, {hi, lo}, exp);
`ifdef BUS_REG_RD_PREFETCH_EN
        if (num == 4) begin
            m_rd_pend = 1;
            serve_read(1, 16'($urandom()));
        end
`endif
    endtask

    initial begin
        logic [15:0] wa, wb;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_rd_byte", {8'h0, rd_byte_o}, 16'h0000);
        chk("rst_req", {15'h0, mem_req_o}, 16'h0000);
        chk("rst_wr", {15'h0, mem_wr_o}, 16'h0000);
        chk("rst_addr", mem_addr_o, 16'h0000);
        chk("rst_data", mem_data_o, 16'h0000);
        reset_n_i = 1'b1;
        tick();
        for (int n = 0; n < 6; n++) rd_check(n, "rst_reg");

        // Basic write with 3-cycle ack latency
        wr_reg(2, 16'h0001);
        wr_reg(3, 16'h1000);
        wr_reg(4, 16'hABCD);
        chk("req_at_t1", {15'h0, mem_req_o}, 16'h0001);
        serve_write(3);
        rd_check(3, "wr_addr_incr");
        wr_reg(9, 16'h1234);
        rd_check(9, "unused_reg");
        tick();
        chk("rd_byte_held", {8'h0, rd_byte_o}, 16'h0000);

        // Address wrap
        wr_reg(3, 16'hFFFF);
        wr_reg(2, 16'h0002);
        wr_reg(4, 16'($urandom()));
        serve_write(1);
        rd_check(3, "wr_addr_wrap");

        // Memory read through RD_ADDR
        wr_reg(0, 16'h0001);
        wr_reg(1, 16'h0200);
        serve_read(2, 16'h55AA);
        rd_check(4, "rd_data");
        rd_check(1, "rd_addr_incr");

        // Overflow and clear
        wr_reg(4, 16'($urandom()));
        wr_reg(4, 16'($urandom()));
        wr_reg(4, 16'($urandom()));
        rd_check(5, "status_ovf");
        wr_reg(5, 16'h4000);
        rd_check(5, "status_clr");
        serve_write(2);
        rd_check(5, "status_idle");

        // Ack coincident with a new DATA write, and write-over-read priority
        wa = 16'($urandom());
        wb = 16'($urandom());
        wr_reg(4, wa);
        wr_reg(1, 16'($urandom()));
        wr_byte(4, 1'b0, wb[15:8]);
        chk("coinc_addr", mem_addr_o, 16'(m_wr_addr));
        mem_ack_i = 1'b1;
        write_strobe_i = 1'b1;
        reg_num_i = 4'd4;
        bytesel_i = 1'b1;
        bytedata_i = wb[7:0];
        tick();
        mem_ack_i = 1'b0;
        write_strobe_i = 1'b0;
        m_wr_addr = (m_wr_addr + m_wr_incr) % 65536;
        m_wr_pend = 0;
        model_write(4, wb);
        chk("coinc_a1", {15'h0, mem_req_o}, 16'h0000);
        tick();
        chk("coinc_a2", {15'h0, mem_req_o}, 16'h0001);
        rd_check(5, "coinc_status");
        serve_write(1);
        serve_read(1, 16'($urandom()));
        rd_check(4, "coinc_rdbuf");
        rd_check(5, "coinc_idle");

        // Randomized transactions
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    if ($urandom_range(0, 1) == 1) wr_reg(2, 16'($urandom()));
                    wr_reg(3, 16'($urandom()));
                    wr_reg(4, 16'($urandom()));
                    serve_write($urandom_range(0, 3));
                    rd_check(3, "rnd_wr_addr");
                end
                1: begin
                    if ($urandom_range(0, 1) == 1) wr_reg(0, 16'($urandom()));
                    wr_reg(1, 16'($urandom()));
                    serve_read($urandom_range(0, 3), 16'($urandom()));
                    rd_check(4, "rnd_rd_data");
                    rd_check(1, "rnd_rd_addr");
                end
                default: begin
                    wr_reg(4, 16'($urandom()));
                    serve_write($urandom_range(0, 3));
                    rd_check(3, "rnd_wr_accum");
                end
            endcase
        end

        // Reset during an outstanding request; a simultaneous ack is ignored
        wr_reg(4, 16'($urandom()));
        chk("pre_rst_req", {15'h0, mem_req_o}, 16'h0001);
        tick();
        reset_n_i = 1'b0;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("rst_mid_req", {15'h0, mem_req_o}, 16'h0000);
        chk("rst_mid_addr", mem_addr_o, 16'h0000);
        chk("rst_mid_byte", {8'h0, rd_byte_o}, 16'h0000);
        tick();
        reset_n_i = 1'b1;
        model_reset();
        tick();
        for (int n = 0; n < 6; n++) rd_check(n, "rst_mid_reg");
        chk("rst_mid_idle", {15'h0, mem_req_o}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
